sub_serial_nbit: RTL and testbench

//   Bit-serial N-bit subtractor: z = a - b - bin, with borrow-out bout.

---
 rtl/sub_serial_pkg.sv | 14 +
 rtl/sub_serial_nbit_fs_1bit.sv | 15 +
 rtl/sub_serial_nbit.sv | 148 ++++++++++++++
 tb/tb_sub_serial_nbit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// rtl/sub_serial_pkg.sv - state encoding and borrow-cell function for the serial subtractor
package sub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

endpackage

// File: rtl/sub_serial_nbit_fs_1bit.sv
// rtl/sub_serial_nbit_fs_1bit.sv - combinational one-bit full subtractor
module fs_1bit
    import sub_serial_pkg::*;
(
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);

    assign d  = a ^ b ^ bi;
    assign bo = fs_borrow(a, b, bi);

endmodule

// File: rtl/sub_serial_nbit.sv
// rtl/sub_serial_nbit.sv - bit-serial N-bit subtractor z = a - b - bin, LSB first
// Optional signed-overflow output enabled by SUB_SERIAL_OVF_EN.
module sub_serial_nbit
    import sub_serial_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  z_q, z_d;
    logic          br_q, br_d;
    logic          bout_q, bout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          fs_d, fs_bo;
    logic [N-1:0]  acc_shift;
`ifdef SUB_SERIAL_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    fs_1bit u_fs (
        .d  (fs_d),
        .bo (fs_bo),
        .a  (opa_q[cnt_q]),
        .b  (opb_q[cnt_q]),
        .bi (br_q)
    );

    // Difference bits enter from the MSB so the LSB ends up at bit 0 after N shifts.
    generate
        if (N == 1) begin : g_shift1
            assign acc_shift = fs_d;
        end else begin : g_shiftn
            assign acc_shift = {fs_d, acc_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        z_d      = z_q;
        br_d     = br_q;
        bout_d   = bout_q;
`ifdef SUB_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_shift;
                br_d  = fs_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    z_d     = acc_shift;
                    bout_d  = fs_bo;
`ifdef SUB_SERIAL_OVF_EN
                    ovf_d   = (opa_q[N-1] ^ opb_q[N-1]) & (opa_q[N-1] ^ fs_d);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            z_q         <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            br_q        <= br_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign bout      = bout_q;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial_nbit.sv
// tb/tb_sub_serial_nbit.sv - directed checks of the serial subtractor at N=4 and N=2 (SUB_SERIAL_OVF_EN aware)
module tb_sub_serial_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid4 = 1'b0, out_ready4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       in_ready4, out_valid4, bout4;
    logic [3:0] z4;
    logic       ovf4;

    logic       in_valid2 = 1'b0, out_ready2 = 1'b0, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       in_ready2, out_valid2, bout2;
    logic [1:0] z2;
    logic       ovf2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sub_serial_nbit #(.N(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .bin       (bin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .z         (z4),
        .bout      (bout4)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    sub_serial_nbit #(.N(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .bin       (bin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .z         (z2),
        .bout      (bout2)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf       (ovf2)
`endif
    );

`ifndef SUB_SERIAL_OVF_EN
    assign ovf4 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ez, input logic eb, input logic eovf, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; bin4 = bi; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd4);
        chk({tag, " z"}, 32'(z4), 32'(ez));
        chk({tag, " bout"}, 32'(bout4), 32'(eb));
`ifdef SUB_SERIAL_OVF_EN
        chk({tag, " ovf"}, 32'(ovf4), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid4), 32'd0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi);
        int n;
        logic [2:0] diff;
        diff = {1'b0, a} - {1'b0, b} - {2'b00, bi};
        @(negedge clk);
        a2 = a; b2 = b; bin2 = bi; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        $display("(%b %b %b) => (%b %b)", a, b, bi, bout2, z2);
        chk("n2 latency", 32'(n), 32'd2);
        chk("n2 z", 32'(z2), 32'(diff[1:0]));
        chk("n2 bout", 32'(bout2), 32'(diff[2]));
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready4), 32'd1);
        chk("rst out_valid", 32'(out_valid4), 32'd0);
        chk("rst z", 32'(z4), 32'd0);
        chk("rst bout", 32'(bout4), 32'd0);
        chk("rst ovf", 32'(ovf4), 32'd0);
        rst = 1'b0;

        op4(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, "v1");
        op4(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, "v2");
        op4(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, "v3");
        op4(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, "v4");
        op4(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, "ovf1");
        op4(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, "ovf2");

        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            op2(v[4:3], v[2:1], v[0]);
        end

        // back-pressure: hold DONE five cycles while a new request is presented
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b0011; bin4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1111; bin4 = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", 32'(out_valid4), 32'd1);
            chk("bp z", 32'(z4), 32'b0010);
            chk("bp bout", 32'(bout4), 32'd0);
            chk("bp in_ready", 32'(in_ready4), 32'd0);
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("bp release out_valid", 32'(out_valid4), 32'd0);
        chk("bp release in_ready", 32'(in_ready4), 32'd1);

        // reset on the second RUN cycle aborts the op
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b0010; bin4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", 32'(in_ready4), 32'd1);
        chk("abort out_valid", 32'(out_valid4), 32'd0);
        chk("abort z", 32'(z4), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("abort no out_valid", 32'(out_valid4), 32'd0);
            @(negedge clk);
        end
        op4(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0, "post_abort");
        op4(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, "ovf3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
